// File: rtl/clock_time_ctrl.sv
// Timekeeping controller: hour/min/sec counters with RUN/SET modes and SET inactivity timeout.
// Optional alarm registers and alarm output enabled by defining CLOCK_TIME_CTRL_ALARM_EN.
module clock_time_ctrl #(
    parameter int unsigned HOUR_MODULO = 24,
    parameter int unsigned SET_TIMEOUT = 30
) (
    input  logic       clk_50MHz,
    input  logic       reset,
    input  logic       tick_1Hz,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [4:0] hour,
    output logic [5:0] min,
    output logic [5:0] sec,
    output logic [2:0] mode,
    output logic       blink,
    output logic       alarm
);

    localparam int unsigned HOUR_W = 5;
    localparam int unsigned MIN_W  = 6;
    localparam int unsigned CNT_W  = 8;

    localparam logic [HOUR_W-1:0] HOUR_LAST = HOUR_W'(HOUR_MODULO - 1);
    localparam logic [MIN_W-1:0]  MIN_LAST  = MIN_W'(59);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SET_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_RUN      = 3'd0,
        S_SET_HOUR = 3'd1,
        S_SET_MIN  = 3'd2,
        S_AL_HOUR  = 3'd3,
        S_AL_MIN   = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [HOUR_W-1:0]  hour_q, hour_d;
    logic [MIN_W-1:0]   min_q, min_d;
    logic [MIN_W-1:0]   sec_q, sec_d;
    logic               blink_q, blink_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [HOUR_W-1:0]  hour_inc;
    logic [MIN_W-1:0]   min_inc;
    logic [MIN_W-1:0]   sec_inc;

`ifdef CLOCK_TIME_CTRL_ALARM_EN
    logic [HOUR_W-1:0]  al_hour_q, al_hour_d;
    logic [MIN_W-1:0]   al_min_q, al_min_d;
    logic               armed_q, armed_d;
    logic               alarm_q, alarm_d;
`endif

    assign hour_inc = (hour_q == HOUR_LAST) ? '0 : hour_q + HOUR_W'(1);
    assign min_inc  = (min_q == MIN_LAST) ? '0 : min_q + MIN_W'(1);
    assign sec_inc  = (sec_q == MIN_LAST) ? '0 : sec_q + MIN_W'(1);

    // Next-state and next-value logic for mode sequencing, counting and editing
    always_comb begin
        state_d = state_q;
        hour_d  = hour_q;
        min_d   = min_q;
        sec_d   = sec_q;
        blink_d = blink_q;
        cnt_d   = cnt_q;
`ifdef CLOCK_TIME_CTRL_ALARM_EN
        al_hour_d = al_hour_q;
        al_min_d  = al_min_q;
        armed_d   = armed_q;
        alarm_d   = 1'b0;
`endif
        if (state_q == S_RUN) begin
            if (tick_1Hz) begin
                sec_d = sec_inc;
                if (sec_q == MIN_LAST) begin
                    min_d = min_inc;
                    if (min_q == MIN_LAST) hour_d = hour_inc;
                end
            end
            if (btn_mode) begin
                state_d = S_SET_HOUR;
                blink_d = 1'b1;
                cnt_d   = '0;
            end
`ifdef CLOCK_TIME_CTRL_ALARM_EN
            else if (btn_inc && alarm_q) begin
                armed_d = 1'b0;
            end
`endif
        end else begin
            if (tick_1Hz) begin
                blink_d = ~blink_q;
                cnt_d   = cnt_q + CNT_W'(1);
            end
            // Any button activity restarts the inactivity window, even on a tick cycle
            if (btn_mode || btn_inc) cnt_d = '0;
            if (btn_mode) begin
                case (state_q)
                    S_SET_HOUR: state_d = S_SET_MIN;
                    S_SET_MIN: begin
                        sec_d = '0;
`ifdef CLOCK_TIME_CTRL_ALARM_EN
                        state_d = S_AL_HOUR;
`else
                        state_d = S_RUN;
`endif
                    end
`ifdef CLOCK_TIME_CTRL_ALARM_EN
                    S_AL_HOUR: state_d = S_AL_MIN;
                    S_AL_MIN: begin
                        state_d = S_RUN;
                        armed_d = 1'b1;
                    end
`endif
                    default: state_d = S_RUN;
                endcase
            end else if (btn_inc) begin
                case (state_q)
                    S_SET_HOUR: hour_d = hour_inc;
                    S_SET_MIN:  min_d  = min_inc;
`ifdef CLOCK_TIME_CTRL_ALARM_EN
                    S_AL_HOUR:  al_hour_d = (al_hour_q == HOUR_LAST) ? '0 : al_hour_q + HOUR_W'(1);
                    S_AL_MIN:   al_min_d  = (al_min_q == MIN_LAST) ? '0 : al_min_q + MIN_W'(1);
`endif
                    default: ;
                endcase
            end else if (tick_1Hz && (cnt_q == CNT_LAST)) begin
                state_d = S_RUN;
                cnt_d   = '0;
            end
            if (state_d == S_RUN) blink_d = 1'b0;
        end
`ifdef CLOCK_TIME_CTRL_ALARM_EN
        // Uses the post-clear armed value so an acknowledge drops alarm on the next cycle
        alarm_d = armed_d && (state_q == S_RUN) && (hour_q == al_hour_q) && (min_q == al_min_q);
`endif
    end

    always_ff @(posedge clk_50MHz or posedge reset) begin
        if (reset) begin
            state_q <= S_RUN;
            hour_q  <= '0;
            min_q   <= '0;
            sec_q   <= '0;
            blink_q <= 1'b0;
            cnt_q   <= '0;
`ifdef CLOCK_TIME_CTRL_ALARM_EN
            al_hour_q <= '0;
            al_min_q  <= '0;
            armed_q   <= 1'b0;
            alarm_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            hour_q  <= hour_d;
            min_q   <= min_d;
            sec_q   <= sec_d;
            blink_q <= blink_d;
            cnt_q   <= cnt_d;
`ifdef CLOCK_TIME_CTRL_ALARM_EN
            al_hour_q <= al_hour_d;
            al_min_q  <= al_min_d;
            armed_q   <= armed_d;
            alarm_q   <= alarm_d;
`endif
        end
    end

    assign hour  = hour_q;
    assign min   = min_q;
    assign sec   = sec_q;
    assign mode  = state_q;
    assign blink = blink_q;
`ifdef CLOCK_TIME_CTRL_ALARM_EN
    assign alarm = alarm_q;
`else
    assign alarm = 1'b0;
`endif

endmodule
